mant_mul_seq: RTL

Sequential radix-2 shift-and-add multiplier for the unsigned significands (hidden bit included) of two floating-point operands. It returns the full double-width product.
- Sits between operand unpacking (upstream) and product normalise/round (downstream).
- Internal accumulation uses a WIDTH+1-bit ripple adder built from the team's full-adder chain.
- Valid/ready handshakes on both sides; one multiply in flight at a time.

---
 rtl/mant_mul_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/mant_mul_seq.sv
// Sequential radix-2 shift-and-add multiplier for unsigned significands.
// One multiply in flight; valid/ready on both sides; fixed WIDTH-edge latency.
module mant_mul_seq #(
  parameter int WIDTH = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_mant_a,
  input  logic [WIDTH-1:0]     i_mant_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // {hi, lo}; the carry bit above hi is always zero after the shift, so it is not stored
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH:0]       carry_s;
  logic [WIDTH:0]       sum_s;

  assign addend_s   = b_q[0] ? a_q : {WIDTH{1'b0}};
  assign carry_s[0] = 1'b0;

  // WIDTH+1-bit ripple adder: hi + addend, carry-out kept as sum_s[WIDTH]
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_s[i]       = acc_q[WIDTH+i] ^ addend_s[i] ^ carry_s[i];
    assign carry_s[i+1]   = (acc_q[WIDTH+i] & addend_s[i]) |
                            (carry_s[i] & (acc_q[WIDTH+i] ^ addend_s[i]));
  end
  assign sum_s[WIDTH] = carry_s[WIDTH];

  // Next-state, datapath and output-flag computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_mant_a;
          b_d     = i_mant_b;
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_product = acc_q;

endmodule
